// File: rtl/clint.sv
// Core-Local Interruptor: bus-mapped msip/mtime/mtimecmp registers feeding the core's
// software/timer interrupt inputs, with a two-state IDLE/ACK bus handshake.
module clint #(
    parameter int unsigned CLOCK_CYCLES = 1,
    parameter int unsigned DATA_SIZE    = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [DATA_SIZE/8-1:0] byte_en,
    input  logic [15:0]            addr,
    input  logic [DATA_SIZE-1:0]   wr_data,
    output logic [DATA_SIZE-1:0]   rd_data,
    output logic                   ack,
    output logic [DATA_SIZE-1:0]   msip,
    output logic [63:0]            mtime,
    output logic [63:0]            mtimecmp
);

    localparam int unsigned NB = DATA_SIZE / 8;

    typedef enum logic {IDLE, ACK} state_t;

    state_t                 state_q;
    logic                   ack_q;
    logic [DATA_SIZE-1:0]   rd_data_q, rd_data_d;
    logic                   msip_q, msip_d;
    logic [63:0]            mtime_q, mtime_d;
    logic [63:0]            mtimecmp_q, mtimecmp_d;
    logic [31:0]            presc_q, presc_d;

    logic                   accept, do_wr, do_rd;
    logic                   sel_msip, sel_cmp, sel_time, time_wr;
    int unsigned            base;
    logic [DATA_SIZE-1:0]   rd_val;

    assign accept = (state_q == IDLE) && (rd_en || wr_en);
    assign do_wr  = accept && wr_en;
    assign do_rd  = accept && rd_en && !wr_en;

    // On a 32-bit bus addr[2] picks the upper word; on a 64-bit bus the +4 aliases are unmapped.
    always_comb begin
        sel_msip = (addr == 16'h0000);
        sel_cmp  = (addr == 16'h4000) || ((DATA_SIZE == 32) && (addr == 16'h4004));
        sel_time = (addr == 16'hBFF8) || ((DATA_SIZE == 32) && (addr == 16'hBFFC));
        base     = ((DATA_SIZE == 32) && addr[2]) ? 4 : 0;
        time_wr  = do_wr && sel_time && (|byte_en);
    end

    always_comb begin
        rd_val = '0;
        if (sel_msip)
            rd_val = DATA_SIZE'(msip_q);
        else if (sel_cmp)
            rd_val = DATA_SIZE'(mtimecmp_q >> (8 * base));
        else if (sel_time)
            rd_val = DATA_SIZE'(mtime_q >> (8 * base));
        rd_data_d = do_rd ? rd_val : '0;
    end

    always_comb begin
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        if (do_wr && sel_msip && byte_en[0])
            msip_d = wr_data[0];
        if (do_wr && sel_cmp) begin
            for (int unsigned i = 0; i < NB; i++)
                if (byte_en[i])
                    mtimecmp_d[(base + i) * 8 +: 8] = wr_data[i * 8 +: 8];
        end
    end

    // A bus write to mtime takes priority over the tick and restarts the prescaler.
    always_comb begin
        mtime_d = mtime_q;
        presc_d = presc_q;
        if (time_wr) begin
            for (int unsigned i = 0; i < NB; i++)
                if (byte_en[i])
                    mtime_d[(base + i) * 8 +: 8] = wr_data[i * 8 +: 8];
            presc_d = '0;
        end else if (presc_q == 32'(CLOCK_CYCLES - 1)) begin
            mtime_d = mtime_q + 64'd1;
            presc_d = '0;
        end else begin
            presc_d = presc_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            rd_data_q  <= '0;
            msip_q     <= 1'b0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            presc_q    <= '0;
        end else begin
            msip_q     <= msip_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            presc_q    <= presc_d;
            case (state_q)
                IDLE: begin
                    ack_q     <= accept;
                    rd_data_q <= rd_data_d;
                    state_q   <= accept ? ACK : IDLE;
                end
                ACK: begin
                    ack_q     <= 1'b0;
                    rd_data_q <= '0;
                    state_q   <= IDLE;
                end
                default: begin
                    ack_q     <= 1'b0;
                    rd_data_q <= '0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign ack      = ack_q;
    assign rd_data  = rd_data_q;
    assign msip     = DATA_SIZE'(msip_q);
    assign mtime    = mtime_q;
    assign mtimecmp = mtimecmp_q;

endmodule

// File: tb/tb_clint.sv
// Scoreboard bench for clint (CLOCK_CYCLES=4, DATA_SIZE=32): bus responses checked by a
// negedge monitor against a queue of expected read data; register outputs checked inline.
module tb_clint;

    localparam int unsigned CC = 4;
    localparam int unsigned DS = 32;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  byte_en = '0;
    logic [15:0] addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        ack;
    logic [31:0] msip;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] data;
        logic [15:0] addr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clock = ~clock;

    clint #(.CLOCK_CYCLES(CC), .DATA_SIZE(DS)) dut (
        .clock    (clock),
        .reset    (reset),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .byte_en  (byte_en),
        .addr     (addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .ack      (ack),
        .msip     (msip),
        .mtime    (mtime),
        .mtimecmp (mtimecmp)
    );

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Monitor: every ack pops one expected response; idle cycles must show rd_data=0.
    always @(negedge clock) begin
        if (ack === 1'b1) begin
            if (sb.size() == 0) begin
                check64("spurious_ack", 64'(ack), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check64($sformatf("rd_data@%h", mon_e.addr), 64'(rd_data), 64'(mon_e.data));
            end
        end else begin
            check64("rd_data_idle", 64'(rd_data), 64'd0);
        end
    end

    task automatic bus(input logic r, input logic w, input logic [3:0] be,
                       input logic [15:0] a, input logic [31:0] d, input logic [31:0] exp);
        exp_t e;
        @(negedge clock);
        rd_en   = r;
        wr_en   = w;
        byte_en = be;
        addr    = a;
        wr_data = d;
        e.data  = exp;
        e.addr  = a;
        sb.push_back(e);
        @(posedge clock);
        #1;
        rd_en = 1'b0;
        wr_en = 1'b0;
        @(negedge clock);
        check64("ack_latency", 64'(ack), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check64("reset_ack", 64'(ack), 64'd0);
        check64("reset_msip", 64'(msip), 64'd0);
        check64("reset_mtimecmp", mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
        check64("reset_mtime", mtime, 64'd0);
        repeat (12) @(posedge clock);
        #1;
        check64("mtime_12cyc", mtime, 64'd3);

        // msip: only bit 0 is stored
        bus(1'b0, 1'b1, 4'hF, 16'h0000, 32'hFFFF_FFFF, 32'h0);
        check64("msip_set", 64'(msip), 64'd1);
        bus(1'b1, 1'b0, 4'h0, 16'h0000, 32'h0, 32'h1);

        // mtimecmp halves and byte strobes
        bus(1'b0, 1'b1, 4'hF, 16'h4000, 32'h10, 32'h0);
        bus(1'b0, 1'b1, 4'hF, 16'h4004, 32'h0, 32'h0);
        check64("mtimecmp_0x10", mtimecmp, 64'h10);
        bus(1'b1, 1'b0, 4'h0, 16'h4000, 32'h0, 32'h10);
        bus(1'b1, 1'b0, 4'h0, 16'h4004, 32'h0, 32'h0);
        bus(1'b0, 1'b1, 4'b0010, 16'h4000, 32'h0000_AB00, 32'h0);
        bus(1'b1, 1'b0, 4'h0, 16'h4000, 32'h0, 32'h0000_AB10);
        bus(1'b0, 1'b1, 4'b1000, 16'h4004, 32'hCD00_0077, 32'h0);
        check64("mtimecmp_bytes", mtimecmp, 64'hCD00_0000_0000_AB10);

        // mtime carry from low into high half
        bus(1'b0, 1'b1, 4'hF, 16'hBFFC, 32'h0, 32'h0);
        bus(1'b0, 1'b1, 4'hF, 16'hBFF8, 32'hFFFF_FFFF, 32'h0);
        repeat (3) @(posedge clock);
        #1;
        check64("mtime_pre_carry", mtime, 64'h0000_0000_FFFF_FFFF);
        @(posedge clock);
        #1;
        check64("mtime_carry", mtime, 64'h0000_0001_0000_0000);

        // write landing on the terminal prescaler count beats the increment
        bus(1'b0, 1'b1, 4'hF, 16'hBFF8, 32'h100, 32'h0);
        check64("mtime_wr1", mtime, 64'h0000_0001_0000_0100);
        repeat (2) @(negedge clock);
        bus(1'b0, 1'b1, 4'hF, 16'hBFF8, 32'h200, 32'h0);
        check64("mtime_wr_wins", mtime, 64'h0000_0001_0000_0200);
        repeat (3) @(posedge clock);
        #1;
        check64("mtime_hold", mtime, 64'h0000_0001_0000_0200);
        @(posedge clock);
        #1;
        check64("mtime_next_tick", mtime, 64'h0000_0001_0000_0201);

        // unmapped accesses and rd+wr together
        bus(1'b1, 1'b0, 4'h0, 16'h1234, 32'h0, 32'h0);
        bus(1'b0, 1'b1, 4'hF, 16'h1234, 32'hDEAD_BEEF, 32'h0);
        check64("unmapped_wr", mtimecmp, 64'hCD00_0000_0000_AB10);
        bus(1'b1, 1'b1, 4'hF, 16'h0000, 32'h0, 32'h0);
        check64("rdwr_msip", 64'(msip), 64'd0);

        // reset on the accept edge discards the write
        @(negedge clock);
        wr_en   = 1'b1;
        byte_en = 4'hF;
        addr    = 16'h4000;
        wr_data = 32'h55;
        reset   = 1'b1;
        @(posedge clock);
        #1;
        wr_en = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        check64("reset_wr_ack", 64'(ack), 64'd0);
        check64("reset_wr_cmp", mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);

        for (int i = 0; i < 10 && sb.size() != 0; i++)
            @(negedge clock);
        check64("sb_drained", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
